// File: rtl/branch_pkg.sv
// Shared types and constants for the ID-stage branch resolution logic.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
package branch_pkg;

    localparam int unsigned PC_W_DEF = 16;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned COND_W   = 3;

    typedef enum logic [COND_W-1:0] {
        NEQ    = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GTE    = 3'b100,
        LTE    = 3'b101,
        OVFL   = 3'b110,
        UNCOND = 3'b111
    } cond_t;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } brstate_t;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        sat_inc = (val == {CNT_W{1'b1}}) ? val : val + CNT_W'(1);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a branch condition code against the Z/N/V flags.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [COND_W-1:0] branch_cond,
    input  logic              flag_Z,
    input  logic              flag_N,
    input  logic              flag_V,
    output logic              cond_true
);

    cond_t w_cond;

    always_comb begin
        w_cond    = cond_t'(branch_cond);
        cond_true = 1'b0;
        unique case (w_cond)
            NEQ:     cond_true = ~flag_Z;
            EQ:      cond_true = flag_Z;
            GT:      cond_true = ~flag_Z & ~flag_N;
            LT:      cond_true = flag_N;
            GTE:     cond_true = flag_Z | (~flag_Z & ~flag_N);
            LTE:     cond_true = flag_N | flag_Z;
            OVFL:    cond_true = flag_V;
            UNCOND:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// ID-stage branch resolution: carries the IF-stage prediction, resolves the branch,
// drives the predictor update bus and redirect/flush. BRANCH_STATS_EN adds counters.
module branch_resolution_unit
    import branch_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [PC_W-1:0]   PC_curr,
    input  logic [PC_W-1:0]   PC_next,
    input  logic              predicted_taken,
    input  logic [PC_W-1:0]   predicted_target,
    input  logic              is_branch,
    input  logic [COND_W-1:0] branch_cond,
    input  logic              flag_Z,
    input  logic              flag_N,
    input  logic              flag_V,
    input  logic [PC_W-1:0]   branch_target,
    output logic [PC_W-1:0]   IF_ID_PC_curr,
    output logic              was_branch,
    output logic              actual_taken,
    output logic [PC_W-1:0]   actual_target,
    output logic              branch_mispredicted,
    output logic              flush_IF_ID,
    output logic [PC_W-1:0]   redirect_PC
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
`endif
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pc_next;
    logic            r_pred_taken;
    logic [PC_W-1:0] r_pred_target;
    logic            r_valid;
    brstate_t        r_state;

    logic            w_cond_true;
    logic            w_was_branch;
    logic            w_actual_taken;
    logic [PC_W-1:0] w_actual_target;
    logic            w_dir_miss;
    logic            w_tgt_miss;
    logic            w_mispred;
    logic [PC_W-1:0] w_redirect;

    branch_cond_eval u_cond_eval (
        .branch_cond (branch_cond),
        .flag_Z      (flag_Z),
        .flag_N      (flag_N),
        .flag_V      (flag_V),
        .cond_true   (w_cond_true)
    );

    // Resolution is combinational on the IF/ID slot; update outputs stay 0 unless a real branch resolves.
    always_comb begin
        w_was_branch    = enable & r_valid & is_branch & (r_state == NORMAL);
        w_actual_taken  = w_was_branch & w_cond_true;
        w_actual_target = w_was_branch ? branch_target : '0;
        w_dir_miss      = r_pred_taken != w_actual_taken;
        w_tgt_miss      = w_actual_taken & (r_pred_target != w_actual_target);
        w_mispred       = w_was_branch & (w_dir_miss | w_tgt_miss);
        w_redirect      = '0;
        if (w_mispred) begin
            w_redirect = w_actual_taken ? w_actual_target : r_pc_next;
        end
    end

    assign IF_ID_PC_curr       = r_pc;
    assign was_branch          = w_was_branch;
    assign actual_taken        = w_actual_taken;
    assign actual_target       = w_actual_target;
    assign branch_mispredicted = w_mispred;
    assign flush_IF_ID         = w_mispred;
    assign redirect_PC         = w_redirect;

    // IF/ID prediction slot and recovery FSM; a flushed capture becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= '0;
            r_pc_next     <= '0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_valid       <= 1'b0;
            r_state       <= NORMAL;
        end else if (enable) begin
            r_pc          <= PC_curr;
            r_pc_next     <= PC_next;
            r_pred_taken  <= predicted_taken;
            r_pred_target <= predicted_target;
            r_valid       <= ~w_mispred;
            unique case (r_state)
                NORMAL:  r_state <= w_mispred ? RECOVER : NORMAL;
                RECOVER: r_state <= NORMAL;
                default: r_state <= NORMAL;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    // Saturating resolved-branch and misprediction counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (enable) begin
            if (w_was_branch) begin
                r_branch_count <= sat_inc(r_branch_count);
            end
            if (w_mispred) begin
                r_mispredict_count <= sat_inc(r_mispredict_count);
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: directed vectors push expectations,
// a negedge monitor pops and compares them.
module tb_branch_resolution_unit;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] PC_curr;
    logic [15:0] PC_next;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic        is_branch;
    logic [2:0]  branch_cond;
    logic        flag_Z;
    logic        flag_N;
    logic        flag_V;
    logic [15:0] branch_target;
    logic [15:0] IF_ID_PC_curr;
    logic        was_branch;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        branch_mispredicted;
    logic        flush_IF_ID;
    logic [15:0] redirect_PC;
`ifdef BRANCH_STATS_EN
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;
`endif

    typedef struct {
        string       nm;
        logic        chk_main;
        logic        wb;
        logic        at;
        logic [15:0] atg;
        logic        mp;
        logic [15:0] rpc;
        logic [15:0] ifpc;
        logic        chk_cnt;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    branch_resolution_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .PC_curr             (PC_curr),
        .PC_next             (PC_next),
        .predicted_taken     (predicted_taken),
        .predicted_target    (predicted_target),
        .is_branch           (is_branch),
        .branch_cond         (branch_cond),
        .flag_Z              (flag_Z),
        .flag_N              (flag_N),
        .flag_V              (flag_V),
        .branch_target       (branch_target),
        .IF_ID_PC_curr       (IF_ID_PC_curr),
        .was_branch          (was_branch),
        .actual_taken        (actual_taken),
        .actual_target       (actual_target),
        .branch_mispredicted (branch_mispredicted),
        .flush_IF_ID         (flush_IF_ID),
        .redirect_PC         (redirect_PC)
`ifdef BRANCH_STATS_EN
        ,
        .branch_count        (branch_count),
        .mispredict_count    (mispredict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic [15:0] pc, input logic [15:0] pcn,
                          input logic pt, input logic [15:0] ptg);
        PC_curr          = pc;
        PC_next          = pcn;
        predicted_taken  = pt;
        predicted_target = ptg;
    endtask

    task automatic set_id(input logic isb, input logic [2:0] c, input logic z,
                          input logic n, input logic v, input logic [15:0] bt);
        is_branch     = isb;
        branch_cond   = c;
        flag_Z        = z;
        flag_N        = n;
        flag_V        = v;
        branch_target = bt;
    endtask

    task automatic push_exp(input string nm, input logic wb, input logic at,
                            input logic [15:0] atg, input logic mp,
                            input logic [15:0] rpc, input logic [15:0] ifpc);
        exp_t e;
        e.nm = nm; e.chk_main = 1'b1; e.wb = wb; e.at = at; e.atg = atg;
        e.mp = mp; e.rpc = rpc; e.ifpc = ifpc;
        e.chk_cnt = 1'b0; e.bc = '0; e.mc = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_cnt(input string nm, input logic [15:0] bc, input logic [15:0] mc);
        exp_t e;
        e.nm = nm; e.chk_main = 1'b0; e.wb = 1'b0; e.at = 1'b0; e.atg = '0;
        e.mp = 1'b0; e.rpc = '0; e.ifpc = '0;
        e.chk_cnt = 1'b1; e.bc = bc; e.mc = mc;
        exp_q.push_back(e);
    endtask

    // Monitor: every expectation queued for this cycle is compared at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk_main) begin
                n_tests++;
                if (was_branch !== e.wb || actual_taken !== e.at || actual_target !== e.atg ||
                    branch_mispredicted !== e.mp || flush_IF_ID !== e.mp ||
                    redirect_PC !== e.rpc || IF_ID_PC_curr !== e.ifpc) begin
                    n_fail++;
                    $display("FAIL %s: got wb=%b at=%b atg=%h mp=%b fl=%b rpc=%h ifpc=%h, want wb=%b at=%b atg=%h mp=%b fl=%b rpc=%h ifpc=%h",
                             e.nm, was_branch, actual_taken, actual_target, branch_mispredicted,
                             flush_IF_ID, redirect_PC, IF_ID_PC_curr,
                             e.wb, e.at, e.atg, e.mp, e.mp, e.rpc, e.ifpc);
                end
            end
`ifdef BRANCH_STATS_EN
            if (e.chk_cnt) begin
                n_tests++;
                if (branch_count !== e.bc || mispredict_count !== e.mc) begin
                    n_fail++;
                    $display("FAIL %s: got branch_count=%h mispredict_count=%h, want %h %h",
                             e.nm, branch_count, mispredict_count, e.bc, e.mc);
                end
            end
`endif
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        set_if(16'h1234, 16'h1236, 1'b1, 16'h5555);
        set_id(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0999);
        tick();
        rst = 1'b0;
        set_if(16'h0010, 16'h0012, 1'b1, 16'h0040);
        push_exp("reset", 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tick();
        set_if(16'h0010, 16'h0012, 1'b0, 16'h0000);
        set_id(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0040);
        push_exp("correct_taken", 1, 1, 16'h0040, 0, 16'h0000, 16'h0010);
        tick();
        set_if(16'h0012, 16'h0014, 1'b0, 16'h0000);
        set_id(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0080);
        push_exp("dir_miss", 1, 1, 16'h0080, 1, 16'h0080, 16'h0010);
        tick();
        set_if(16'h0080, 16'h0082, 1'b1, 16'h0100);
        set_id(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0200);
        push_exp("recover_bubble", 0, 0, 16'h0000, 0, 16'h0000, 16'h0012);
        tick();
        set_if(16'h0082, 16'h0084, 1'b0, 16'h0000);
        set_id(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0104);
        push_exp("target_miss", 1, 1, 16'h0104, 1, 16'h0104, 16'h0080);
        tick();
        set_if(16'h0104, 16'h0106, 1'b1, 16'h0300);
        set_id(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0300);
        push_exp("recover_nonbranch", 0, 0, 16'h0000, 0, 16'h0000, 16'h0082);
        tick();
        set_if(16'h0020, 16'h0022, 1'b1, 16'h0050);
        push_exp("nonbranch_pred_taken", 0, 0, 16'h0000, 0, 16'h0000, 16'h0104);
        tick();
        enable = 1'b0;
        set_if(16'h7777, 16'h7779, 1'b0, 16'h0000);
        set_id(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 16'h0050);
        push_exp("stall1", 0, 0, 16'h0000, 0, 16'h0000, 16'h0020);
        tick();
        push_exp("stall2", 0, 0, 16'h0000, 0, 16'h0000, 16'h0020);
        tick();
        enable = 1'b1;
        set_if(16'h0022, 16'h0024, 1'b0, 16'h0000);
        push_exp("nt_miss_after_stall", 1, 0, 16'h0050, 1, 16'h0022, 16'h0020);
        tick();
        enable = 1'b0;
        set_id(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0099);
        push_exp("recover_stall", 0, 0, 16'h0000, 0, 16'h0000, 16'h0022);
        tick();
        enable = 1'b1;
        set_if(16'h0030, 16'h0032, 1'b0, 16'h0000);
        push_exp("recover_exit", 0, 0, 16'h0000, 0, 16'h0000, 16'h0022);
        tick();
        set_if(16'h0032, 16'h0034, 1'b1, 16'h0070);
        set_id(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 16'h0060);
        push_exp("correct_not_taken", 1, 0, 16'h0060, 0, 16'h0000, 16'h0030);
        tick();
        set_if(16'h0034, 16'h0036, 1'b1, 16'h0090);
        set_id(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 16'h0070);
        push_exp("lte_false_miss", 1, 0, 16'h0070, 1, 16'h0034, 16'h0032);
        push_cnt("cnt_pre_reset", 16'd5, 16'd3);
        tick();
        rst = 1'b1;
        set_if(16'h0040, 16'h0042, 1'b1, 16'h0044);
        set_id(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0000);
        push_exp("pre_reset_recover", 0, 0, 16'h0000, 0, 16'h0000, 16'h0034);
        tick();
        rst = 1'b0;
        set_id(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0044);
        push_exp("reset_mid_recover", 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        push_cnt("cnt_after_reset", 16'd0, 16'd0);
        tick();
        set_if(16'h0044, 16'h0046, 1'b1, 16'h0048);
        push_exp("taken_after_reset", 1, 1, 16'h0044, 0, 16'h0000, 16'h0040);
        tick();
        set_if(16'h0046, 16'h0048, 1'b0, 16'h0000);
        set_id(1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0049);
        push_exp("gte_target_lsb", 1, 1, 16'h0049, 1, 16'h0049, 16'h0044);
        tick();
        set_if(16'h0049, 16'h004B, 1'b1, 16'h0010);
        set_id(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0000);
        push_exp("recover3", 0, 0, 16'h0000, 0, 16'h0000, 16'h0046);
        tick();
        set_if(16'h0010, 16'h0012, 1'b0, 16'h0000);
        set_id(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 16'h0010);
        push_exp("ovfl_taken", 1, 1, 16'h0010, 0, 16'h0000, 16'h0049);
        tick();
        set_if(16'h0010, 16'h0012, 1'b1, 16'h0010);
        set_id(1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 16'h0040);
        push_exp("gt_false", 1, 0, 16'h0040, 0, 16'h0000, 16'h0010);
        tick();
        set_id(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0010);
        push_exp("steady_taken", 1, 1, 16'h0010, 0, 16'h0000, 16'h0010);
        push_cnt("cnt_4_branches", 16'd4, 16'd1);
`ifdef BRANCH_STATS_EN
        repeat (65540) @(posedge clk);
        #1;
        push_cnt("branch_count_saturate", 16'hFFFF, 16'd1);
`endif
        tick();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
